// File: rtl/switch_pkt_buffer.sv
// switch_pkt_buffer: store-and-forward packet FIFO; commits whole packets only, replays on ready/valid egress, with conf-bus counters.
module switch_pkt_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] packet_in,
  input  logic              packet_in_start,
  output logic              packet_ack,
  output logic [DATA_W-1:0] packet_out,
  output logic              packet_out_start,
  output logic              packet_out_valid,
  input  logic              packet_out_ready,
  input  logic [3:0]        conf_address,
  input  logic              conf_data_valid,
  input  logic              conf_read_write,
  input  logic [15:0]       conf_data_write,
  output logic [15:0]       conf_data_read
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int NW = (DATA_W > PW ? DATA_W : PW) + 1;
  localparam logic [DATA_W-1:0] ONE_D = 1;
  localparam logic [PW-1:0] ONE_P = 1;
  localparam logic [CNT_W-1:0] ONE_C = 1;

  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DROP} rx_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_t;

  rx_t rx_q, rx_d;
  tx_t tx_q, tx_d;
  logic [DATA_W-1:0] rlen_q, rlen_d, tlen_q, tlen_d;
  logic [PW-1:0] wspec_q, wspec_d, wcom_q, wcom_d, rd_q, rd_d, pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic ack_q, ack_d, en_q, en_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [PW-1:0] base, free;
  logic [NW-1:0] need;
  logic [AW-1:0] waddr;
  logic [1:0] drop_inc;
  logic [CNT_W:0] drop_sum;
  logic we, commit, abort, hdr_drop, fire, hdr_fire, wr_en, rd_en, clr, rx_clr, drop_clr;
  logic unused_ok;

  assign unused_ok = ^conf_data_write[15:2];
  assign rd_word = mem_q[rd_q[AW-1:0]];
  assign packet_out_valid = (tx_q == TX_SEND) || (pkt_cnt_q != '0);
  assign packet_out_start = (tx_q == TX_IDLE) && packet_out_valid;
  assign packet_out = packet_out_valid ? rd_word : '0;
  assign packet_ack = ack_q;
  assign conf_data_read = rdata_q;

  // A restarting header is checked against the committed pointer, so an abort frees its words first
  always_comb begin
    rx_d = rx_q;
    rlen_d = rlen_q;
    wspec_d = wspec_q;
    wcom_d = wcom_q;
    ack_d = 1'b0;
    we = 1'b0;
    commit = 1'b0;
    waddr = wspec_q[AW-1:0];
    base = (rx_q == RX_RECV) ? wcom_q : wspec_q;
    free = PW'(DEPTH) - (base - rd_q);
    need = NW'(packet_in) + NW'(1);
    abort = packet_in_start && (rx_q == RX_RECV);
    hdr_drop = packet_in_start && ((packet_in == '0) || !en_q || (need > NW'(free)));
    if (packet_in_start) begin
      wspec_d = base;
      rlen_d = packet_in;
      rx_d = (packet_in == '0) ? RX_IDLE : hdr_drop ? RX_DROP : RX_RECV;
      if (!hdr_drop) begin
        we = 1'b1;
        waddr = base[AW-1:0];
        wspec_d = base + ONE_P;
      end
    end else if (rx_q == RX_RECV) begin
      we = 1'b1;
      wspec_d = wspec_q + ONE_P;
      rlen_d = rlen_q - ONE_D;
      if (rlen_q == ONE_D) begin
        wcom_d = wspec_q + ONE_P;
        ack_d = 1'b1;
        commit = 1'b1;
        rx_d = RX_IDLE;
      end
    end else if (rx_q == RX_DROP) begin
      rlen_d = rlen_q - ONE_D;
      rx_d = (rlen_q == ONE_D) ? RX_IDLE : RX_DROP;
    end
  end

  always_comb begin
    tx_d = tx_q;
    tlen_d = tlen_q;
    hdr_fire = 1'b0;
    fire = packet_out_valid && packet_out_ready;
    if (tx_q == TX_IDLE && fire) begin
      tx_d = TX_SEND;
      tlen_d = rd_word;
      hdr_fire = 1'b1;
    end else if (tx_q == TX_SEND && fire) begin
      tlen_d = tlen_q - ONE_D;
      tx_d = (tlen_q == ONE_D) ? TX_IDLE : TX_SEND;
    end
    rd_d = rd_q + PW'(fire);
    pkt_cnt_d = pkt_cnt_q + PW'(commit) - PW'(hdr_fire);
  end

  always_comb begin
    wr_en = conf_data_valid && !conf_read_write;
    rd_en = conf_data_valid && conf_read_write;
    clr = wr_en && conf_address == 4'h0 && conf_data_write[1];
    en_d = (wr_en && conf_address == 4'h0) ? conf_data_write[0] : en_q;
    rx_clr = clr || (wr_en && conf_address == 4'h1);
    drop_clr = clr || (wr_en && conf_address == 4'h2);
    drop_inc = {1'b0, abort} + {1'b0, hdr_drop};
    drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_inc);
    rx_cnt_d = rx_clr ? '0 : (commit && !(&rx_cnt_q)) ? rx_cnt_q + ONE_C : rx_cnt_q;
    drop_cnt_d = drop_clr ? '0 : drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    rdata_d = !rd_en ? rdata_q :
              conf_address == 4'h0 ? 16'(en_q) :
              conf_address == 4'h1 ? 16'(rx_cnt_q) :
              conf_address == 4'h2 ? 16'(drop_cnt_q) :
              conf_address == 4'h3 ? 16'(wspec_q - rd_q) : 16'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q <= RX_IDLE;
      tx_q <= TX_IDLE;
      rlen_q <= '0;
      tlen_q <= '0;
      wspec_q <= '0;
      wcom_q <= '0;
      rd_q <= '0;
      pkt_cnt_q <= '0;
      rx_cnt_q <= '0;
      drop_cnt_q <= '0;
      rdata_q <= '0;
      ack_q <= 1'b0;
      en_q <= 1'b1;
    end else begin
      rx_q <= rx_d;
      tx_q <= tx_d;
      rlen_q <= rlen_d;
      tlen_q <= tlen_d;
      wspec_q <= wspec_d;
      wcom_q <= wcom_d;
      rd_q <= rd_d;
      pkt_cnt_q <= pkt_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      rdata_q <= rdata_d;
      ack_q <= ack_d;
      en_q <= en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[waddr] <= packet_in;
  end
endmodule

// File: tb/tb_switch_pkt_buffer.sv
// tb_switch_pkt_buffer: directed checks of ingress commit/drop/abort, egress backpressure, conf registers and reset.
module tb_switch_pkt_buffer;
  logic clk = 0, rst = 1;
  logic [7:0] packet_in = 0;
  logic packet_in_start = 0, packet_out_ready = 0;
  logic packet_ack, packet_out_start, packet_out_valid;
  logic [7:0] packet_out;
  logic [3:0] conf_address = 0;
  logic conf_data_valid = 0, conf_read_write = 0;
  logic [15:0] conf_data_write = 0, conf_data_read;
  int vectors = 0, miscompares = 0, cyc = 0;
  logic hold_p = 0, pat_mode = 0;
  logic [8:0] prev_word = 0;
  logic [3:0] pat = 4'b1001;
  logic [10:0] log_q[$];
  logic [8:0] out_q[$], exp_q[$];

  switch_pkt_buffer dut (
    .clk(clk), .rst(rst), .packet_in(packet_in), .packet_in_start(packet_in_start),
    .packet_ack(packet_ack), .packet_out(packet_out), .packet_out_start(packet_out_start),
    .packet_out_valid(packet_out_valid), .packet_out_ready(packet_out_ready),
    .conf_address(conf_address), .conf_data_valid(conf_data_valid),
    .conf_read_write(conf_read_write), .conf_data_write(conf_data_write),
    .conf_data_read(conf_data_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) begin
      if (hold_p) chk("hold", {packet_out_valid, packet_out_start, packet_out}, {1'b1, prev_word});
      log_q.push_back({packet_out_ready, packet_out_valid, packet_out_start, packet_out});
      if (packet_out_valid && packet_out_ready) out_q.push_back({packet_out_start, packet_out});
      hold_p = packet_out_valid && !packet_out_ready;
      prev_word = {packet_out_start, packet_out};
    end else hold_p = 0;
    @(posedge clk);
    #1;
    cyc++;
    if (pat_mode) packet_out_ready = pat[cyc % 4];
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] len, input logic [7:0] first, input logic [7:0] inc);
    packet_in = len;
    packet_in_start = 1;
    step();
    packet_in_start = 0;
    for (int k = 0; k < int'(len); k++) begin
      packet_in = first + 8'(k) * inc;
      step();
    end
    packet_in = 0;
  endtask

  task automatic conf_wr(input logic [3:0] a, input logic [15:0] d);
    conf_address = a;
    conf_data_write = d;
    conf_read_write = 0;
    conf_data_valid = 1;
    step();
    conf_data_valid = 0;
  endtask

  task automatic conf_rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
    conf_address = a;
    conf_read_write = 1;
    conf_data_valid = 1;
    step();
    conf_data_valid = 0;
    chk(tag, conf_data_read, exp);
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < out_q.size()) ? {23'h0, out_q[i]} : 32'hdead, {23'h0, exp_q[i]});
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int idx;
    logic found;
    steps(2);
    rst = 0;
    chk("rst_ack", packet_ack, 0);
    chk("rst_valid", packet_out_valid, 0);
    chk("rst_start", packet_out_start, 0);
    chk("rst_out", packet_out, 0);
    chk("rst_rdata", conf_data_read, 0);
    conf_rd("rst_ctrl", 4'h0, 16'h0001);
    conf_rd("rst_level", 4'h3, 16'h0000);

    packet_out_ready = 1;
    send(8'd3, 8'hAA, 8'h11);
    chk("t1_ack", packet_ack, 1);
    step();
    chk("t1_ack_pulse", packet_ack, 0);
    steps(6);
    exp_q = '{9'h103, 9'h0AA, 9'h0BB, 9'h0CC};
    chk_out("t1_egress");
    conf_rd("t1_rxcnt", 4'h1, 16'd1);
    conf_rd("t1_level", 4'h3, 16'd0);

    log_q.delete();
    pat_mode = 1;
    packet_out_ready = pat[cyc % 4];
    send(8'd2, 8'h11, 8'h11);
    send(8'd2, 8'h33, 8'h11);
    steps(20);
    pat_mode = 0;
    packet_out_ready = 1;
    exp_q = '{9'h102, 9'h011, 9'h022, 9'h102, 9'h033, 9'h044};
    chk_out("t2_egress");
    idx = 0;
    found = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (!found && log_q[i][10] && log_q[i][9] && log_q[i][8:0] == 9'h022) begin
        found = 1;
        idx = i;
      end
    chk("t2_last_found", found, 1);
    chk("t2_b2b_header", (idx + 1 < log_q.size()) ? {22'h0, log_q[idx+1][9:0]} : 32'hdead, {22'h0, 10'h302});

    conf_wr(4'h0, 16'h0003);
    packet_out_ready = 0;
    send(8'd62, 8'h00, 8'h01);
    chk("t3_ack62", packet_ack, 1);
    conf_rd("t3_level63", 4'h3, 16'd63);
    send(8'd1, 8'h55, 8'h01);
    chk("t3_noack", packet_ack, 0);
    conf_rd("t3_drop", 4'h2, 16'd1);
    conf_rd("t3_level_still", 4'h3, 16'd63);
    packet_out_ready = 1;
    steps(70);
    exp_q.push_back(9'h13E);
    for (int i = 0; i < 62; i++) exp_q.push_back(9'(i));
    chk_out("t3_drain");
    conf_rd("t3_level0", 4'h3, 16'd0);
    send(8'd1, 8'h55, 8'h01);
    chk("t3_ack_retry", packet_ack, 1);
    steps(4);
    exp_q = '{9'h101, 9'h055};
    chk_out("t3_retry");

    conf_wr(4'h0, 16'h0003);
    packet_out_ready = 0;
    packet_in = 8'h05; packet_in_start = 1; step();
    packet_in = 8'h10; packet_in_start = 0; step();
    packet_in = 8'h20; step();
    packet_in = 8'h01; packet_in_start = 1; step();
    packet_in = 8'h77; packet_in_start = 0;
    conf_address = 4'h3; conf_read_write = 1; conf_data_valid = 1;
    step();
    conf_data_valid = 0;
    packet_in = 0;
    chk("t4_level_rewound", conf_data_read, 16'd1);
    chk("t4_ack", packet_ack, 1);
    conf_rd("t4_level", 4'h3, 16'd2);
    conf_rd("t4_drop", 4'h2, 16'd1);
    conf_rd("t4_rxcnt", 4'h1, 16'd1);
    packet_out_ready = 1;
    steps(5);
    exp_q = '{9'h101, 9'h077};
    chk_out("t4_egress");

    conf_wr(4'h2, 16'h0000);
    conf_wr(4'h0, 16'h0000);
    send(8'd2, 8'h01, 8'h01);
    chk("t5_noack", packet_ack, 0);
    conf_rd("t5_drop", 4'h2, 16'd1);
    step();
    chk("t5_drop_hold", conf_data_read, 16'd1);
    conf_wr(4'h2, 16'h0005);
    conf_rd("t5_drop_clr", 4'h2, 16'd0);
    conf_rd("t5_unmapped", 4'h7, 16'd0);
    conf_rd("t5_ctrl", 4'h0, 16'd0);
    steps(3);
    chk("t5_no_egress", out_q.size(), 0);
    conf_wr(4'h0, 16'h0001);

    packet_in = 8'h03; packet_in_start = 1; step();
    packet_in = 8'hA1; packet_in_start = 0; step();
    packet_in = 8'hA2; rst = 1; step();
    rst = 0; packet_in = 0;
    chk("t6a_ack", packet_ack, 0);
    chk("t6a_valid", packet_out_valid, 0);
    chk("t6a_out", packet_out, 0);
    conf_rd("t6a_level", 4'h3, 16'd0);
    packet_out_ready = 0;
    send(8'd3, 8'hC1, 8'h01);
    chk("t6b_ack", packet_ack, 1);
    packet_out_ready = 1;
    step();
    chk("t6b_in_send", packet_out, 8'hC1);
    rst = 1; step();
    rst = 0;
    chk("t6b_ack", packet_ack, 0);
    chk("t6b_valid", packet_out_valid, 0);
    chk("t6b_start", packet_out_start, 0);
    chk("t6b_out", packet_out, 0);
    chk("t6b_rdata", conf_data_read, 0);
    conf_rd("t6b_level", 4'h3, 16'd0);
    out_q.delete();
    send(8'd2, 8'h5A, 8'h01);
    chk("t6c_ack", packet_ack, 1);
    steps(5);
    exp_q = '{9'h102, 9'h05A, 9'h05B};
    chk_out("t6c_egress");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
